// File: rtl/load_pkg.sv
// Shared types for the MEM-stage load unit: load-type codes, FSM states and access-size helper.
package load_pkg;

    typedef enum logic [1:0] {
        LD_WORD  = 2'b00,
        LD_BYTE  = 2'b01,
        LD_HALF  = 2'b10,
        LD_DWORD = 2'b11
    } ld_type_e;

    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StWait0,
        StReq1,
        StWait1,
        StResp,
        StDrain
    } load_state_e;

    // Access size in bytes; a dword degrades to a word on a 32-bit datapath.
    function automatic int unsigned size_of(input ld_type_e t, input int unsigned xlen);
        case (t)
            LD_BYTE:  return 1;
            LD_HALF:  return 2;
            LD_DWORD: return (xlen == 64) ? 8 : 4;
            default:  return 4;
        endcase
    endfunction

endpackage

// File: rtl/load_lane_extract.sv
// Combinational byte-lane selector: shifts {word1,word0} down by the byte offset, keeps the
// access-size low bytes and sign/zero-extends them to XLEN.
module load_lane_extract
    import load_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]            word0,
    input  logic [XLEN-1:0]            word1,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  ld_type_e                   ld_type,
    input  logic                       sign,
    output logic [XLEN-1:0]            data
);

    localparam int unsigned DwMsb = (XLEN == 64) ? 63 : 31;

    logic [XLEN-1:0] shifted;
    logic            ext;
    int unsigned     nbits;

    always_comb begin
        shifted = XLEN'({word1, word0} >> {off, 3'b000});
        nbits   = 8 * size_of(ld_type, XLEN);
        ext     = 1'b0;
        unique case (ld_type)
            LD_BYTE:  ext = sign & shifted[7];
            LD_HALF:  ext = sign & shifted[15];
            LD_WORD:  ext = sign & shifted[31];
            LD_DWORD: ext = sign & shifted[DwMsb];
            default:  ext = 1'b0;
        endcase
        data = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            data[i] = (i < nbits) ? shifted[i] : ext;
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// MEM-stage load unit: word-aligned RAM reads, byte selection and extension, two-beat split
// for loads crossing a word boundary when LOAD_SPLIT_EN is defined (otherwise flagged via rsp_err).
module load_align_unit
    import load_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_type,
    input  logic              req_sign,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_err
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

`ifdef LOAD_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    ld_type_e          type_q, type_d;
    logic              sign_q, sign_d;
    logic [XLEN-1:0]   word0_q, word0_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [ADDR_W-1:0] word_addr;
    logic [XLEN-1:0]   ext_lo, ext_hi, ext_data;
    logic              req_split, cur_split;

    function automatic logic is_split(input logic [OFF_W-1:0] off, input ld_type_e t);
        return (32'(off) + size_of(t, XLEN)) > NB;
    endfunction

    assign word_addr = addr_q & ~ADDR_W'(NB - 1);
    assign req_split = is_split(req_addr[OFF_W-1:0], ld_type_e'(req_type));
    assign cur_split = is_split(addr_q[OFF_W-1:0], type_q);

    // In WAIT1 the first beat is already held; otherwise the arriving word is the low half.
    assign ext_lo = (state_q == StWait1) ? word0_q : mem_rdata;
    assign ext_hi = (state_q == StWait1) ? mem_rdata : '0;

    load_lane_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .word0   (ext_lo),
        .word1   (ext_hi),
        .off     (addr_q[OFF_W-1:0]),
        .ld_type (type_q),
        .sign    (sign_q),
        .data    (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        type_d     = type_q;
        sign_d     = sign_q;
        word0_d    = word0_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        rsp_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid && !flush) begin
                    addr_d = req_addr;
                    type_d = ld_type_e'(req_type);
                    sign_d = req_sign;
                    if (req_split && !SplitEn) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = StResp;
                    end else begin
                        state_d = StReq0;
                    end
                end
            end
            StReq0: begin
                mem_req  = 1'b1;
                mem_addr = word_addr;
                if (flush) begin
                    state_d = mem_gnt ? StDrain : StIdle;
                end else if (mem_gnt) begin
                    state_d = StWait0;
                end
            end
            StWait0: begin
                if (mem_rvalid) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else if (SplitEn && cur_split) begin
                        word0_d = mem_rdata;
                        state_d = StReq1;
                    end else begin
                        rsp_data_d = ext_data;
                        rsp_err_d  = 1'b0;
                        state_d    = StResp;
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StReq1: begin
                mem_req  = 1'b1;
                mem_addr = word_addr + ADDR_W'(NB);
                if (flush) begin
                    state_d = mem_gnt ? StDrain : StIdle;
                end else if (mem_gnt) begin
                    state_d = StWait1;
                end
            end
            StWait1: begin
                if (mem_rvalid) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else begin
                        rsp_data_d = ext_data;
                        rsp_err_d  = 1'b0;
                        state_d    = StResp;
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StResp: begin
                // A flush drops the response, so it must not be seen as valid that cycle.
                rsp_valid = !flush;
                if (flush || rsp_ready) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (mem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            type_q     <= LD_WORD;
            sign_q     <= 1'b0;
            word0_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            type_q     <= type_d;
            sign_q     <= sign_d;
            word0_q    <= word0_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed self-checking bench for load_align_unit (XLEN=32); split-load checks follow LOAD_SPLIT_EN.
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, req_sign;
    logic [31:0] req_addr;
    logic [1:0]  req_type;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;

    int tests = 0;
    int fails = 0;

    // RAM model: grant when enabled, read data after rlat cycles.
    logic        gnt_en = 1'b1;
    int          rlat = 1;
    logic [31:0] ram [0:255];
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] gnt_log [$];

    always #5 clk = ~clk;

    assign mem_gnt = mem_req & gnt_en;

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    end

    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (pend) begin
            if (pend_cnt <= 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= ram[pend_addr[9:2]];
                pend       <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
        if (mem_req && mem_gnt) begin
            gnt_log.push_back(mem_addr);
            if (rlat <= 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= ram[mem_addr[9:2]];
            end else begin
                pend      <= 1'b1;
                pend_cnt  <= rlat - 1;
                pend_addr <= mem_addr;
            end
        end
    end

    load_align_unit #(
        .XLEN   (32),
        .ADDR_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_type   (req_type),
        .req_sign   (req_sign),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one load from IDLE (called at a negedge), wait bounded for the response, accept it.
    task automatic do_load(input logic [31:0] a, input logic [1:0] t, input logic s,
                           output logic [31:0] d, output logic e, output int lat);
        req_valid = 1'b1;
        req_addr  = a;
        req_type  = t;
        req_sign  = s;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_timeout", rsp_valid, 1);
        d = rsp_data;
        e = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [31:0] d;
    logic        e;
    int          lat;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0;
        req_type = 2'b00; req_sign = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);

        // 1: aligned word, cycle-by-cycle
        ram[8'h40] = 32'h8000_00F0;
        req_valid = 1'b1; req_addr = 32'h100; req_type = 2'b00; req_sign = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("t1_c1_mem_req", mem_req, 1);
        check("t1_c1_mem_addr", mem_addr, 32'h100);
        check("t1_c1_req_ready", req_ready, 0);
        @(negedge clk);
        check("t1_c2_mem_req", mem_req, 0);
        check("t1_c2_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("t1_c3_rsp_valid", rsp_valid, 1);
        check("t1_data", rsp_data, 32'h8000_00F0);
        check("t1_err", rsp_err, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t1_after_valid", rsp_valid, 0);
        check("t1_after_ready", req_ready, 1);

        // 2: byte signed/unsigned, plus in-word misaligned halves
        ram[8'h40] = 32'h80FF_7F01;
        do_load(32'h103, 2'b01, 1'b1, d, e, lat);
        check("t2_byte_s", d, 32'hFFFF_FF80);
        check("t2_lat", lat, 3);
        do_load(32'h103, 2'b01, 1'b0, d, e, lat);
        check("t2_byte_u", d, 32'h0000_0080);
        do_load(32'h101, 2'b01, 1'b1, d, e, lat);
        check("t2_byte_pos", d, 32'h0000_007F);
        do_load(32'h101, 2'b10, 1'b1, d, e, lat);
        check("t2_half_off1", d, 32'hFFFF_FF7F);
        check("t2_half_off1_err", e, 0);
        do_load(32'h102, 2'b10, 1'b0, d, e, lat);
        check("t2_half_off2_u", d, 32'h0000_80FF);
        do_load(32'h100, 2'b11, 1'b1, d, e, lat);
        check("t2_dword_as_word", d, 32'h80FF_7F01);

        // 3/4: half spanning two words
        ram[8'h40] = 32'hAB00_0000;
        ram[8'h41] = 32'h0000_00CD;
        gnt_log.delete();
        do_load(32'h103, 2'b10, 1'b1, d, e, lat);
`ifdef LOAD_SPLIT_EN
        check("t3_data", d, 32'hFFFF_CDAB);
        check("t3_err", e, 0);
        check("t3_nreq", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("t3_addr0", gnt_log[0], 32'h100);
            check("t3_addr1", gnt_log[1], 32'h104);
        end
        do_load(32'h102, 2'b00, 1'b0, d, e, lat);
        check("t3_word_split", d, 32'h00CD_AB00);
`else
        check("t4_data", d, 32'h0);
        check("t4_err", e, 1);
        check("t4_nreq", gnt_log.size(), 0);
        check("t4_lat", lat, 1);
        do_load(32'h100, 2'b00, 1'b0, d, e, lat);
        check("t4_err_clears", e, 0);
`endif

        // 5: flush in WAIT0 with rvalid two cycles after grant
        rlat = 2;
        req_valid = 1'b1; req_addr = 32'h100; req_type = 2'b00; req_sign = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("t5_wait0_mem_req", mem_req, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t5_drain_rvalid", mem_rvalid, 1);
        check("t5_drain_req_ready", req_ready, 0);
        check("t5_drain_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("t5_idle_req_ready", req_ready, 1);
        check("t5_idle_rsp_valid", rsp_valid, 0);
        rlat = 1;

        // flush in REQ0 without grant -> straight back to IDLE
        gnt_en = 1'b0;
        req_valid = 1'b1; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        gnt_en = 1'b1;
        check("fl_req0_ready", req_ready, 1);
        check("fl_req0_mem_req", mem_req, 0);

        // flush in IDLE blocks a same-cycle request
        req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        check("fl_idle_ready", req_ready, 1);
        check("fl_idle_mem_req", mem_req, 0);

        // 6: backpressure
        ram[8'h42] = 32'h1234_5678;
        req_valid = 1'b1; req_addr = 32'h10A; req_type = 2'b10; req_sign = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t6_valid", rsp_valid, 1);
            check("t6_data", rsp_data, 32'h0000_1234);
            check("t6_req_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t6_done_valid", rsp_valid, 0);
        check("t6_done_ready", req_ready, 1);

        // reset mid-operation
        req_valid = 1'b1; req_addr = 32'h100; req_type = 2'b00;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_data", rsp_data, 0);
        @(negedge clk);
        check("mid_rst_no_rsp", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
